uart_rx_axis: RTL and testbench

- Standalone UART receiver: samples the serial `rx` line, deserializes LSB-first frames, checks parity and stop bits, and presents each byte on an AXI-Stream master port with a single-entry output register.
- Sits at the far end of a UART link, e.g. the board-side peer or a second port paired with the existing UART transmitter in loopback benches.
- Standalone, it gives the link an independently verified receive endpoint.

---
 rtl/uart_rx_axis.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_rx_axis.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// uart_rx_axis
// ------------
// UART receiver with an AXI-Stream master output.
//
// The serial line is synchronised, framed (start / data LSB-first / optional
// parity / one or two stop bits) and each good byte is presented through a
// single-entry output register.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst_n          asynchronous reset, active HIGH despite the legacy name
//   rx_en          receive enable, only looked at while idle
//   rx             asynchronous serial input, idles high
//   m_axis_tdata   received data word
//   m_axis_tvalid  output register holds a word
//   m_axis_tready  downstream accept
//   m_axis_tuser   parity error flag belonging to m_axis_tdata
//   frame_err      one-cycle pulse, a stop bit was sampled low
//   overrun_err    one-cycle pulse, a finished word was dropped (register full)
//   busy           high whenever the receiver is not idle
module uart_rx_axis #(
    parameter int system_clk = 50000000,
    parameter int band_rate  = 115200,
    parameter int data_bits  = 8,
    parameter int check_mode = 1,
    parameter int stop_mode  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [data_bits-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV   = system_clk / band_rate;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(data_bits + 1);
    localparam logic HAS_PARITY = (check_mode != 0);
    localparam logic TWO_STOP   = (stop_mode == 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Parity check: XOR of data and parity bit must be 0 (even) or 1 (odd).
    function automatic logic parity_err(input logic [data_bits-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (check_mode == 2) ? ~x : x;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic                 fall_s;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 stop_idx_r;
    logic [data_bits-1:0] shift_r;
    logic                 par_err_r;
    logic                 tick_s;
    logic                 half_tick_s;
    logic                 cnt_clr_s;
    logic                 shift_en_s;
    logic                 par_en_s;
    logic                 stop_adv_s;
    logic                 deliver_s;
    logic                 frame_s;
    logic [data_bits-1:0] tdata_r;
    logic                 tvalid_r;
    logic                 tuser_r;
    logic                 frame_err_r;
    logic                 overrun_err_r;
    logic                 busy_r;

    assign fall_s      = rx_prev_r & ~rx_sync_r;
    assign tick_s      = (baud_cnt_r == CNT_W'(DIV - 1));
    assign half_tick_s = (baud_cnt_r == CNT_W'(HALF - 1));

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and per-cycle datapath strobes
    always_comb begin
        state_next_s = state_r;
        cnt_clr_s    = 1'b0;
        shift_en_s   = 1'b0;
        par_en_s     = 1'b0;
        stop_adv_s   = 1'b0;
        deliver_s    = 1'b0;
        frame_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_en && fall_s) begin
                    state_next_s = ST_START;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Re-check the line half a bit in to reject glitches.
                if (half_tick_s) begin
                    cnt_clr_s = 1'b1;
                    if (!rx_sync_r) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_en_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    if (bit_cnt_r == BIT_W'(data_bits - 1)) begin
                        state_next_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    par_en_s     = 1'b1;
                    cnt_clr_s    = 1'b1;
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave mid-stop-bit on success so the next start edge is seen.
                if (tick_s) begin
                    cnt_clr_s = 1'b1;
                    if (!rx_sync_r) begin
                        frame_s      = 1'b1;
                        state_next_s = ST_BREAK;
                    end else if (TWO_STOP && !stop_idx_r) begin
                        stop_adv_s   = 1'b1;
                        state_next_s = ST_STOP;
                    end else begin
                        deliver_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_sync_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Baud and bit counters, shift register and parity result of the frame in flight
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            stop_idx_r <= 1'b0;
            shift_r    <= {data_bits{1'b0}};
            par_err_r  <= 1'b0;
        end else begin
            if (cnt_clr_s || (state_r == ST_IDLE) || (state_r == ST_BREAK)) begin
                baud_cnt_r <= {CNT_W{1'b0}};
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            end
            if (state_r == ST_IDLE) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
            if (shift_en_s) begin
                shift_r <= {rx_sync_r, shift_r[data_bits-1:1]};
            end
            if (state_r == ST_START) begin
                par_err_r <= 1'b0;
            end else if (par_en_s) begin
                par_err_r <= parity_err(shift_r, rx_sync_r);
            end
            if (state_r != ST_STOP) begin
                stop_idx_r <= 1'b0;
            end else if (stop_adv_s) begin
                stop_idx_r <= 1'b1;
            end
        end
    end

    // Output register, AXIS handshake and status pulses
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tdata_r       <= {data_bits{1'b0}};
            tvalid_r      <= 1'b0;
            tuser_r       <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_err_r   <= frame_s;
            overrun_err_r <= deliver_s && tvalid_r && !m_axis_tready;
            busy_r        <= (state_next_s != ST_IDLE);
            // Load when empty or being emptied this cycle; otherwise hold.
            if (deliver_s && (!tvalid_r || m_axis_tready)) begin
                tdata_r  <= shift_r;
                tuser_r  <= par_err_r;
                tvalid_r <= 1'b1;
            end else if (m_axis_tready) begin
                tvalid_r <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tuser  = tuser_r;
    assign frame_err     = frame_err_r;
    assign overrun_err   = overrun_err_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Testbench for uart_rx_axis: a default instance (DIV=434, 8 bits, even
// parity, one stop) and a fast instance (DIV=16, odd parity, two stops).
module tb_uart_rx_axis;

    localparam int DIV0 = 434;
    localparam int DIV1 = 16;

    logic       clk;
    logic       rst_n;
    logic       rx_en, rx, tready;
    logic [7:0] tdata;
    logic       tvalid, tuser, frame_err, overrun_err, busy;
    logic       rx_en2, rx2, tready2;
    logic [7:0] tdata2;
    logic       tvalid2, tuser2, frame_err2, overrun_err2, busy2;

    uart_rx_axis dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .frame_err(frame_err), .overrun_err(overrun_err),
        .busy(busy)
    );

    uart_rx_axis #(.system_clk(1600), .band_rate(100), .data_bits(8),
                   .check_mode(2), .stop_mode(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en2), .rx(rx2),
        .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
        .m_axis_tuser(tuser2), .frame_err(frame_err2), .overrun_err(overrun_err2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accepted words as {tuser, tdata}, pulse counters, tvalid rise time
    logic [8:0] rxq[$];
    logic [8:0] rxq2[$];
    int frame_cnt = 0, ovr_cnt = 0, frame_cnt2 = 0;
    int tv_rise_cyc = 0;
    logic tv_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            if (tvalid && tready) rxq.push_back({tuser, tdata});
            if (tvalid2 && tready2) rxq2.push_back({tuser2, tdata2});
            if (frame_err) frame_cnt++;
            if (frame_err2) frame_cnt2++;
            if (overrun_err) ovr_cnt++;
            if (tvalid && !tv_prev) tv_rise_cyc = cyc;
            tv_prev = tvalid;
        end else begin
            tv_prev = 1'b0;
        end
    end

    int total_cnt = 0;
    int pass_cnt  = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx = v;
        else rx2 = v;
        wait_cyc(n);
    endtask

    // One frame; parity follows each instance's mode, flip corrupts it.
    // stop_low holds the line low for two bit times in place of the stop bit.
    task automatic send_frame(input int which, input logic [7:0] d,
                              input logic flip, input logic stop_low);
        int   div;
        int   ns;
        logic p;
        div = (which == 0) ? DIV0 : DIV1;
        ns  = (which == 0) ? 1 : 2;
        p   = ((which == 0) ? (^d) : ~(^d)) ^ flip;
        if (which == 0) start_cyc = cyc;
        drive(which, 1'b0, div);
        for (int i = 0; i < 8; i++) drive(which, d[i], div);
        drive(which, p, div);
        if (stop_low) begin
            drive(which, 1'b0, 2 * div);
            drive(which, 1'b1, div);
        end else begin
            for (int s = 0; s < ns; s++) drive(which, 1'b1, div);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop_low;
        int         exp_n;
        logic       exp_user;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[4];
    logic [7:0] stream[3];

    initial begin
        int n0, f0, o0, lat;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 0, 1'b0, 1};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1, 1'b0, 0};
        vecs[3] = '{8'h80, 1'b0, 1'b0, 1, 1'b0, 0};
        stream[0] = 8'h00; stream[1] = 8'hFF; stream[2] = 8'h80;

        rx = 1'b1; rx2 = 1'b1; rx_en = 1'b1; rx_en2 = 1'b1;
        tready = 1'b1; tready2 = 1'b1;
        rst_n = 1'b1;
        wait_cyc(5);
        check("reset_outputs", {tdata, tvalid, tuser, frame_err, overrun_err, busy}, 32'h0);
        check("reset_outputs2", {tdata2, tvalid2, tuser2, frame_err2, overrun_err2, busy2}, 32'h0);
        rst_n = 1'b0;
        wait_cyc(10);

        // Nominal 0xA5, also checks latency and the mid-stop-bit return to idle
        n0 = rxq.size(); f0 = frame_cnt;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0);
            begin
                wait_cyc(10 * DIV0 + 100);
                check("nom_busy_before_stop_sample", busy, 1);
                wait_cyc(226);
                check("nom_busy_mid_stop", busy, 0);
                check("nom_count_mid_stop", rxq.size() - n0, 1);
            end
        join
        wait_cyc(DIV0);
        check("nom_word", (rxq.size() > n0) ? rxq[n0] : 9'h1FF, {1'b0, 8'hA5});
        check("nom_single", rxq.size() - n0, 1);
        check("nom_no_frame_err", frame_cnt - f0, 0);
        lat = tv_rise_cyc - start_cyc;
        check("nom_latency_window", (lat >= 4560 && lat <= 4562) ? 1 : 0, 1);

        // Table: parity error, framing error, recovery, odd-weight data
        for (int v = 0; v < 4; v++) begin
            n0 = rxq.size(); f0 = frame_cnt;
            send_frame(0, vecs[v].data, vecs[v].flip, vecs[v].stop_low);
            wait_cyc(DIV0);
            check($sformatf("vec%0d_count", v), rxq.size() - n0, vecs[v].exp_n);
            if (vecs[v].exp_n > 0 && rxq.size() > n0)
                check($sformatf("vec%0d_word", v), rxq[n0], {vecs[v].exp_user, vecs[v].data});
            check($sformatf("vec%0d_frame_err_cycles", v), frame_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_idle", v), busy, 0);
        end

        // False start: 100-cycle glitch
        n0 = rxq.size();
        rx = 1'b0;
        wait_cyc(50);
        check("glitch_busy_early", busy, 1);
        wait_cyc(50);
        rx = 1'b1;
        wait_cyc(130);
        check("glitch_busy_dropped", busy, 0);
        wait_cyc(DIV0);
        check("glitch_no_output", rxq.size() - n0, 0);

        // rx_en low for a whole frame, then dropped mid-frame
        rx_en = 1'b0;
        send_frame(0, 8'h7E, 1'b0, 1'b0);
        wait_cyc(DIV0);
        check("rxen_off_no_output", rxq.size() - n0, 0);
        rx_en = 1'b1;
        fork
            send_frame(0, 8'h7E, 1'b0, 1'b0);
            begin
                wait_cyc(1000);
                rx_en = 1'b0;
            end
        join
        wait_cyc(DIV0);
        check("rxen_fall_count", rxq.size() - n0, 1);
        check("rxen_fall_word", (rxq.size() > n0) ? rxq[n0] : 9'h1FF, {1'b0, 8'h7E});
        rx_en = 1'b1;

        // Backpressure and overrun
        n0 = rxq.size(); o0 = ovr_cnt;
        tready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0);
        wait_cyc(20);
        check("bp_tvalid_held", tvalid, 1);
        check("bp_tdata_held", tdata, 8'h11);
        check("bp_overrun_once", ovr_cnt - o0, 1);
        check("bp_no_accept", rxq.size() - n0, 0);
        tready = 1'b1;
        wait_cyc(2);
        check("bp_tvalid_cleared", tvalid, 0);
        check("bp_accept_once", rxq.size() - n0, 1);
        check("bp_word", (rxq.size() > n0) ? rxq[n0] : 9'h1FF, {1'b0, 8'h11});

        // Reset during bit 4 of 0x99, held until the frame has gone by
        n0 = rxq.size();
        fork
            send_frame(0, 8'h99, 1'b0, 1'b0);
            begin
                wait_cyc(5 * DIV0 + 130);
                check("rst_busy_before", busy, 1);
                rst_n = 1'b1;
                wait_cyc(2);
                check("rst_mid_outputs", {tdata, tvalid, tuser, frame_err, overrun_err, busy}, 32'h0);
            end
        join
        rst_n = 1'b0;
        wait_cyc(DIV0);
        check("rst_no_delivery", rxq.size() - n0, 0);
        check("rst_idle_after", busy, 0);

        // Back-to-back streaming, default instance
        n0 = rxq.size();
        for (int k = 0; k < 3; k++) send_frame(0, stream[k], 1'b0, 1'b0);
        wait_cyc(DIV0);
        check("stream_count", rxq.size() - n0, 3);
        for (int k = 0; k < 3; k++)
            if (rxq.size() > n0 + k)
                check($sformatf("stream_word%0d", k), rxq[n0 + k], {1'b0, stream[k]});

        // Back-to-back streaming, odd parity / two stop bits
        n0 = rxq2.size();
        for (int k = 0; k < 3; k++) send_frame(1, stream[k], 1'b0, 1'b0);
        send_frame(1, 8'h3C, 1'b1, 1'b0);
        f0 = frame_cnt2;
        send_frame(1, 8'h5A, 1'b0, 1'b1);
        wait_cyc(4 * DIV1);
        check("stream2_count", rxq2.size() - n0, 4);
        for (int k = 0; k < 3; k++)
            if (rxq2.size() > n0 + k)
                check($sformatf("stream2_word%0d", k), rxq2[n0 + k], {1'b0, stream[k]});
        check("odd_parity_err_word", (rxq2.size() > n0 + 3) ? rxq2[n0 + 3] : 9'h000, {1'b1, 8'h3C});
        check("dut2_frame_err", frame_cnt2 - f0, 1);
        check("dut2_idle", busy2, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
